// File: rtl/fetch_arb_pkg.sv
// Shared types and default geometry for the fetch bus arbiter.
// way_idx_t and the pointer width follow the default way count and FIFO depth.
package fetch_arb_pkg;
  localparam int NUM_WAYS_P  = 2;
  localparam int MAX_OUTST_P = 4;
  localparam int WAY_IDX_W   = $clog2(NUM_WAYS_P);
  localparam int FIFO_PTR_W  = $clog2(MAX_OUTST_P);
  localparam int FIFO_CNT_W  = FIFO_PTR_W + 1;

  typedef logic [WAY_IDX_W-1:0] way_idx_t;

  typedef struct packed {
    way_idx_t way;
    logic     drop;
  } outst_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester
// strictly after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);
  always_comb begin
    int   k;
    logic found;
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    k            = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && eligible[k]) begin
        found           = 1'b1;
        grant_onehot[k] = 1'b1;
        grant_idx       = k[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/fetch_bus_arbiter.sv
// Shares the instruction bus between fetch ways and routes in-order responses
// back to the issuing way, dropping responses for ways that have jumped.
module fetch_bus_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int NUM_WAYS  = NUM_WAYS_P,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = MAX_OUTST_P
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WAYS-1:0]        way_req_i,
  input  logic [NUM_WAYS*ADDR_W-1:0] way_addr_i,
  input  logic [NUM_WAYS-1:0]        way_flush_i,
  output logic [NUM_WAYS-1:0]        way_gnt_o,
  output logic [NUM_WAYS-1:0]        way_dataOk_o,
  output logic [DATA_W-1:0]          way_rdata_o,
  output logic                       bus_req_o,
  output logic [ADDR_W-1:0]          bus_addr_o,
  input  logic                       bus_ready_i,
  input  logic                       bus_rvalid_i,
  input  logic [DATA_W-1:0]          bus_rdata_i,
  output logic                       err_o
);
  localparam int PTR_W = FIFO_PTR_W;
  localparam int CNT_W = FIFO_CNT_W;

  outst_entry_t        fifo_q [MAX_OUTST];
  outst_entry_t        fifo_d [MAX_OUTST];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  way_idx_t            rr_ptr_q, rr_ptr_d;
  logic [NUM_WAYS-1:0] dataok_q, dataok_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [NUM_WAYS-1:0] eligible, grant_onehot;
  way_idx_t            gnt_idx;
  logic                full, empty, push, pop, deliver;
  outst_entry_t        head;

  rr_arbiter #(.N(NUM_WAYS)) u_rr (
    .eligible     (eligible),
    .ptr          (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (gnt_idx)
  );

  always_comb begin
    eligible   = way_req_i & ~way_flush_i;
    full       = (count_q == CNT_W'(MAX_OUTST));
    empty      = (count_q == '0);
    bus_req_o  = (|eligible) & ~full;
    bus_addr_o = (|eligible) ? way_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
    push       = bus_req_o & bus_ready_i;
    way_gnt_o  = push ? grant_onehot : '0;
    pop        = bus_rvalid_i & ~empty;
    head       = fifo_q[rd_ptr_q];
    // A flush landing on the head in its pop cycle still discards the response.
    deliver    = pop & ~(head.drop | way_flush_i[head.way]);
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    rr_ptr_d = push ? gnt_idx : rr_ptr_q;
    dataok_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q | (bus_rvalid_i & empty);
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (way_flush_i[fifo_q[i].way]) fifo_d[i].drop = 1'b1;
    end
    if (push) fifo_d[wr_ptr_q] = '{way: gnt_idx, drop: 1'b0};
    if (deliver) begin
      dataok_d[head.way] = 1'b1;
      rdata_d            = bus_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= way_idx_t'(NUM_WAYS - 1);
      dataok_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      dataok_q <= dataok_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign way_dataOk_o = dataok_q;
  assign way_rdata_o  = rdata_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Directed bench for fetch_bus_arbiter with a queue-based reference model
// checked every cycle plus literal expectations on logged grants/responses.
module tb_fetch_bus_arbiter;
  localparam int NW  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NW-1:0]   way_req_i, way_flush_i;
  logic [NW*AW-1:0] way_addr_i;
  logic [NW-1:0]   way_gnt_o, way_dataOk_o;
  logic [DW-1:0]   way_rdata_o;
  logic            bus_req_o;
  logic [AW-1:0]   bus_addr_o;
  logic            bus_ready_i, bus_rvalid_i;
  logic [DW-1:0]   bus_rdata_i;
  logic            err_o;

  fetch_bus_arbiter #(.NUM_WAYS(NW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAX)) dut (
    .clk(clk), .reset(reset),
    .way_req_i(way_req_i), .way_addr_i(way_addr_i), .way_flush_i(way_flush_i),
    .way_gnt_o(way_gnt_o), .way_dataOk_o(way_dataOk_o), .way_rdata_o(way_rdata_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_ready_i(bus_ready_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding fetches as an issue-ordered queue.
  int            mq_way[$];
  bit            mq_drop[$];
  int            m_rr;
  logic [NW-1:0] m_ok;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  function automatic int model_winner();
    for (int i = 1; i <= NW; i++) begin
      int k;
      k = (m_rr + i) % NW;
      if (way_req_i[k] && !way_flush_i[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq_way.delete();
      mq_drop.delete();
      m_rr    = NW - 1;
      m_ok    = '0;
      m_rdata = '0;
      m_err   = 1'b0;
    end else begin
      int w, hw;
      bit acc, hd;
      w   = model_winner();
      acc = (w >= 0) && (mq_way.size() < MAX) && bus_ready_i;
      m_ok = '0;
      if (bus_rvalid_i) begin
        if (mq_way.size() == 0) m_err = 1'b1;
        else begin
          hw = mq_way.pop_front();
          hd = mq_drop.pop_front();
          if (!hd && !way_flush_i[hw]) begin
            m_ok[hw] = 1'b1;
            m_rdata  = bus_rdata_i;
          end
        end
      end
      for (int i = 0; i < mq_way.size(); i++)
        if (way_flush_i[mq_way[i]]) mq_drop[i] = 1'b1;
      if (acc) begin
        mq_way.push_back(w);
        mq_drop.push_back(1'b0);
        m_rr = w;
      end
    end
  end

  int            g_log[$];
  int            d_way[$];
  logic [DW-1:0] d_dat[$];

  always @(negedge clk) begin
    if (!reset) begin
      int w;
      logic          e_req;
      logic [NW-1:0] e_gnt;
      logic [AW-1:0] e_addr;
      w      = model_winner();
      e_req  = (w >= 0) && (mq_way.size() < MAX);
      e_gnt  = '0;
      if (e_req && bus_ready_i) e_gnt[w] = 1'b1;
      e_addr = (w >= 0) ? way_addr_i[w*AW +: AW] : '0;
      chk("bus_req", 64'(bus_req_o), 64'(e_req));
      chk("bus_addr", 64'(bus_addr_o), 64'(e_addr));
      chk("gnt", 64'(way_gnt_o), 64'(e_gnt));
      chk("dataOk", 64'(way_dataOk_o), 64'(m_ok));
      chk("rdata", 64'(way_rdata_o), 64'(m_rdata));
      chk("err", 64'(err_o), 64'(m_err));
      if (way_gnt_o != '0) g_log.push_back(int'(way_gnt_o));
      for (int i = 0; i < NW; i++)
        if (way_dataOk_o[i]) begin
          d_way.push_back(i);
          d_dat.push_back(way_rdata_o);
        end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NW-1:0] req, input logic [NW-1:0] fl,
                       input logic rv, input logic [DW-1:0] rd);
    way_req_i    = req;
    way_flush_i  = fl;
    bus_rvalid_i = rv;
    bus_rdata_i  = rd;
    cyc();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    way_req_i    = '0;
    way_flush_i  = '0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    bus_ready_i  = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    g_log.delete();
    d_way.delete();
    d_dat.delete();
  endtask

  initial begin
    way_addr_i = '0;
    do_reset();
    chk("rst_gnt", 64'(way_gnt_o), 64'h0);
    chk("rst_ok", 64'(way_dataOk_o), 64'h0);
    chk("rst_rdata", 64'(way_rdata_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);

    // way0 alone: three fetches, responses two cycles behind
    way_addr_i[63:32] = 32'h100;
    way_addr_i[31:0] = 32'h0; drive(2'b01, 2'b00, 1'b0, 32'h0);
    way_addr_i[31:0] = 32'h4; drive(2'b01, 2'b00, 1'b0, 32'h0);
    way_addr_i[31:0] = 32'h8; drive(2'b01, 2'b00, 1'b1, 32'hA0);
    drive(2'b00, 2'b00, 1'b1, 32'hA1);
    drive(2'b00, 2'b00, 1'b1, 32'hA2);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    cyc();
    chk("s1_ngnt", g_log.size(), 3);
    chk("s1_nresp", d_way.size(), 3);
    if (d_dat.size() == 3) begin
      chk("s1_d0", d_dat[0], 32'hA0);
      chk("s1_d1", d_dat[1], 32'hA1);
      chk("s1_d2", d_dat[2], 32'hA2);
      chk("s1_way", d_way[2], 0);
    end

    // both ways, no responses: alternate grants until FIFO full
    do_reset();
    way_addr_i[31:0] = 32'h40;
    for (int i = 0; i < 6; i++) drive(2'b11, 2'b00, 1'b0, 32'h0);
    chk("s2_ngnt", g_log.size(), 4);
    if (g_log.size() == 4) begin
      chk("s2_g0", g_log[0], 1);
      chk("s2_g1", g_log[1], 2);
      chk("s2_g2", g_log[2], 1);
      chk("s2_g3", g_log[3], 2);
    end
    chk("s2_full_req", 64'(bus_req_o), 64'h0);
    drive(2'b11, 2'b00, 1'b1, 32'h77);
    drive(2'b11, 2'b00, 1'b0, 32'h0);
    chk("s3_ngnt", g_log.size(), 5);
    if (g_log.size() == 5) chk("s3_g4", g_log[4], 1);
    chk("s3_full_req", 64'(bus_req_o), 64'h0);
    chk("s3_resp", d_dat.size() > 0 ? d_dat[0] : 32'h0, 32'h77);
    for (int i = 0; i < 4; i++) drive(2'b00, 2'b00, 1'b1, 32'h90 + i);
    drive(2'b00, 2'b00, 1'b0, 32'h0);

    // W0,W1,W0 outstanding, way0 flushed: only way1's response survives
    do_reset();
    drive(2'b01, 2'b00, 1'b0, 32'h0);
    drive(2'b10, 2'b00, 1'b0, 32'h0);
    drive(2'b01, 2'b00, 1'b0, 32'h0);
    drive(2'b00, 2'b01, 1'b0, 32'h0);
    drive(2'b00, 2'b00, 1'b1, 32'h11);
    drive(2'b00, 2'b00, 1'b1, 32'h22);
    drive(2'b00, 2'b00, 1'b1, 32'h33);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    cyc();
    chk("s4_nresp", d_way.size(), 1);
    if (d_way.size() == 1) begin
      chk("s4_way", d_way[0], 1);
      chk("s4_dat", d_dat[0], 32'h22);
    end

    // flush coincides with the head's response
    do_reset();
    drive(2'b01, 2'b00, 1'b0, 32'h0);
    way_req_i = 2'b11; way_flush_i = 2'b01; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55;
    #1;
    chk("s5_gnt", 64'(way_gnt_o), 64'h2);
    cyc();
    drive(2'b00, 2'b00, 1'b1, 32'h66);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    cyc();
    chk("s5_nresp", d_way.size(), 1);
    if (d_way.size() == 1) begin
      chk("s5_way", d_way[0], 1);
      chk("s5_dat", d_dat[0], 32'h66);
    end

    // response with nothing outstanding, then reset clears the sticky error
    do_reset();
    drive(2'b00, 2'b00, 1'b1, 32'hEE);
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    cyc();
    chk("s6_err", 64'(err_o), 64'h1);
    cyc();
    chk("s6_err_hold", 64'(err_o), 64'h1);
    reset = 1'b1;
    #1;
    chk("s6_rst_err", 64'(err_o), 64'h0);
    chk("s6_rst_req", 64'(bus_req_o), 64'h0);
    chk("s6_rst_ok", 64'(way_dataOk_o), 64'h0);
    cyc();
    reset = 1'b0;
    drive(2'b01, 2'b00, 1'b0, 32'h0);
    chk("s6_post_gnt", g_log.size() > 0 ? g_log[g_log.size()-1] : 0, 1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
